ps2_note_tx: RTL and testbench
==============================

// Module: ps2_note_tx
// PURPOSE
//  Device-side PS/2 set-2 transmitter: converts a 3-bit note into make/break scancode bytes (1:16h, 2:1Eh, 3:26h, F0h break prefix).
//  Serialises each byte as a PS/2 frame on generated ps2_clk/ps2_data. Drives the keyboard-decode path for loopback and emulation.
// PARAMETERS
//  HALF_PERIOD  2500  clk cycles per ps2_clk half period (10 kHz at 50 MHz)
//  GAP_CYCLES   5000  idle clk cycles, lines high, after each stop bit
//  REPEAT_CYC   25000000  typematic repeat interval in clk cycles (used only with PS2_TYPEMATIC_EN)
// PORTS
//  clk       in   1  system clock
//  rst       in   1  asynchronous reset, active-high
//  note      in   3  requested note; 0 or 4..7 = no key held
//  ps2_clk   out  1  PS/2 clock to host, idle high
//  ps2_data  out  1  PS/2 data to host, idle high
//  busy      out  1  high while a scancode sequence is in flight (incl. gap)
//  byte_done out  1  one-cycle pulse at end of each byte's stop bit
// BEHAVIOUR
//  - Reset (async, any state): ps2_clk=1, ps2_data=1, busy=0, byte_done=0; sent_note=0; queue cleared; FSM=IDLE.
//  - IDLE: each cycle compare norm(note) against sent_note (norm maps 4..7 -> 0). On mismatch, capture new=norm(note), build queue, set busy next cycle.
//  - Queue build, in order, max 3 bytes:
//    - if sent_note!=0: F0, code(sent_note)
//    - if new!=0: code(new)
//  - Set sent_note=new at capture.
//  - note changes during a sequence are ignored; re-compared in IDLE after the sequence completes (e.g. 1->2 mid-send yields a second sequence).
//  - Frame: 11 bits: start 0, D0..D7 LSB first, odd parity (D^parity has odd 1-count), stop 1.
//  - Per bit: set ps2_data while ps2_clk high, hold HALF_PERIOD; drive ps2_clk low HALF_PERIOD (host samples on falling edge); release high.
//  - FSM: IDLE -> LOAD (pop byte, form 11-bit shift reg) -> BIT_HI -> BIT_LO -> (next bit: BIT_HI | after stop: GAP) -> LOAD if queue non-empty, else IDLE.
//  - GAP: lines high for GAP_CYCLES; byte_done pulses on the GAP entry cycle.
//  - busy deasserts the cycle FSM re-enters IDLE.
//  - Latency: first ps2_clk falling edge = 2 + HALF_PERIOD cycles after mismatch seen.
//  - Frame time: 22*HALF_PERIOD cycles + GAP_CYCLES.
//  - Counters are width $clog2 of the largest parameter + 1; no wrap while active.
//  - No host-inhibit sensing: the lines are outputs only; the host->device direction is out of scope.
// CONFIGURATION
//  PS2_TYPEMATIC_EN defined:
//   - while in IDLE with sent_note!=0 and no mismatch, a repeat counter runs.
//   - after REPEAT_CYC cycles it queues code(sent_note) alone and restarts the count.
//   - the counter clears on any sequence start.
//  Undefined: make code sent once per press; REPEAT_CYC unused.
// STRUCTURE
//  - Package ps2_kbd_pkg:
//    - KC_NOTE1=8'h16, KC_NOTE2=8'h1E, KC_NOTE3=8'h26, KC_BREAK=8'hF0
//    - NOTE_W=3
//    - function note_to_kc(note)
//  - Sub-module ps2_frame_tx: byte serialiser.
//    - Ports: start/data[7:0] in; ready/done out.
//    - Owns BIT_HI/BIT_LO/GAP and the half-period and gap counters.
//  - Top owns the note compare, the 3-entry queue and sent_note.
// TESTING  (HALF_PERIOD=4, GAP_CYCLES=8, host model samples ps2_data on ps2_clk fall)
//  1. Reset, note=0 for 100 cycles:
//     - ps2_clk=ps2_data=1
//     - busy=0, no byte_done
//  2. note 0->1: exactly one frame.
//     - bits 0,0110_1000,0,1 (16h LSB-first, parity 0)
//     - byte_done x1, then busy=0
//  3. note 1->3: bytes F0,26 in order.
//     - F0 parity 1, 26 parity 0
//     - two byte_done pulses
//     - gap >= 8 cycles of lines high between frames
//  4. note 2->0 then 0 held: bytes F0,1E only.
//     - note=5 afterwards produces no traffic (normalised to 0)
//  5. note 0->1, then note=2 mid-frame:
//     - 16h frame completes
//     - then F0,16,1E sequence
//  6. rst pulse mid-BIT_LO:
//     - ps2_clk/ps2_data go 1 asynchronously, busy=0
//     - with note=1 held, re-sends 16h after release
//     - with PS2_TYPEMATIC_EN, REPEAT_CYC=200 and note=1 held: 16h repeats every 200 IDLE cycles

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared scancode constants, FSM state types and note helpers for the PS/2 note transmitter.
package ps2_kbd_pkg;

  localparam int unsigned NOTE_W = 3;

  localparam logic [7:0] KC_NOTE1 = 8'h16;
  localparam logic [7:0] KC_NOTE2 = 8'h1E;
  localparam logic [7:0] KC_NOTE3 = 8'h26;
  localparam logic [7:0] KC_BREAK = 8'hF0;

  typedef logic [NOTE_W-1:0] note_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_BIT_HI,
    F_BIT_LO,
    F_GAP
  } frame_state_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_LOAD,
    T_SEND
  } top_state_e;

  function automatic logic [7:0] note_to_kc(input note_t note);
    case (note)
      3'd1:    note_to_kc = KC_NOTE1;
      3'd2:    note_to_kc = KC_NOTE2;
      3'd3:    note_to_kc = KC_NOTE3;
      default: note_to_kc = 8'h00;
    endcase
  endfunction

  // Notes 4..7 are not keys and read as "no key held".
  function automatic note_t note_norm(input note_t note);
    note_norm = (note > 3'd3) ? '0 : note;
  endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// PS/2 device-side byte serialiser: start, 8 data bits LSB first, odd parity, stop, then idle gap.
module ps2_frame_tx
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2500,
  parameter int unsigned GAP_CYCLES  = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       done,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int unsigned MAXC = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  frame_state_e r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [10:0]   r_shift, w_shift_nxt;
  logic [3:0]    r_bits, w_bits_nxt;
  logic          r_ps2_clk, r_ps2_data, r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_bits_nxt  = r_bits;
    case (r_state)
      F_IDLE: begin
        if (start) begin
          w_shift_nxt = {1'b1, ~^data, data, 1'b0};
          w_bits_nxt  = 4'd10;
          w_cnt_nxt   = '0;
          w_state_nxt = F_BIT_HI;
        end
      end
      F_BIT_HI: begin
        if (r_cnt == HP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = F_BIT_LO;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      F_BIT_LO: begin
        if (r_cnt == HP_LAST) begin
          w_cnt_nxt = '0;
          if (r_bits == 4'd0) begin
            w_state_nxt = F_GAP;
          end else begin
            w_shift_nxt = {1'b1, r_shift[10:1]};
            w_bits_nxt  = r_bits - 4'd1;
            w_state_nxt = F_BIT_HI;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      F_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = F_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = F_IDLE;
    endcase
  end

  // Line levels are registered from the next state so the pins never glitch on decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= F_IDLE;
      r_cnt      <= '0;
      r_shift    <= '1;
      r_bits     <= '0;
      r_ps2_clk  <= 1'b1;
      r_ps2_data <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_bits     <= w_bits_nxt;
      r_ps2_clk  <= (w_state_nxt != F_BIT_LO);
      r_ps2_data <= (w_state_nxt == F_BIT_HI || w_state_nxt == F_BIT_LO) ? w_shift_nxt[0] : 1'b1;
      r_done     <= (w_state_nxt == F_GAP) && (r_state != F_GAP);
    end
  end

  // Ready on the last gap cycle so the next byte loads without a dead cycle.
  assign ready    = (r_state == F_IDLE) || (r_state == F_GAP && r_cnt == GAP_LAST);
  assign done     = r_done;
  assign ps2_clk  = r_ps2_clk;
  assign ps2_data = r_ps2_data;

endmodule

// File: rtl/ps2_note_tx.sv
// Note-to-scancode PS/2 transmitter: queues make/break bytes on note changes and serialises them.
// Optional typematic repeat of the held note is enabled by defining PS2_TYPEMATIC_EN.
module ps2_note_tx
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2500,
  parameter int unsigned GAP_CYCLES  = 5000,
  parameter int unsigned REPEAT_CYC  = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NOTE_W-1:0] note,
  output logic              ps2_clk,
  output logic              ps2_data,
  output logic              busy,
  output logic              byte_done
);

  top_state_e  r_state, w_state_nxt;
  note_t       r_sent, w_sent_nxt;
  logic [7:0]  r_q [3];
  logic [7:0]  w_q_nxt [3];
  logic [1:0]  r_qlen, w_qlen_nxt;
  logic        r_busy;
  note_t       w_new;
  logic        w_mismatch, w_start, w_ready, w_rep_fire;

  assign w_new      = note_norm(note);
  assign w_mismatch = (r_state == T_IDLE) && (w_new != r_sent);

`ifdef PS2_TYPEMATIC_EN
  localparam int unsigned RW = $clog2(REPEAT_CYC) + 1;
  logic [RW-1:0] r_rep;

  assign w_rep_fire = (r_state == T_IDLE) && !w_mismatch && (r_sent != '0) &&
                      (r_rep == RW'(REPEAT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep <= '0;
    end else if (r_state != T_IDLE || w_mismatch || r_sent == '0 || w_rep_fire) begin
      r_rep <= '0;
    end else begin
      r_rep <= r_rep + 1'b1;
    end
  end
`else
  logic w_unused_repeat;
  assign w_unused_repeat = (REPEAT_CYC == 0);
  assign w_rep_fire      = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_sent_nxt  = r_sent;
    w_q_nxt     = r_q;
    w_qlen_nxt  = r_qlen;
    w_start     = 1'b0;
    case (r_state)
      T_IDLE: begin
        if (w_mismatch) begin
          w_sent_nxt  = w_new;
          w_state_nxt = T_LOAD;
          if (r_sent != '0) begin
            w_q_nxt[0] = KC_BREAK;
            w_q_nxt[1] = note_to_kc(r_sent);
            w_q_nxt[2] = note_to_kc(w_new);
            w_qlen_nxt = (w_new != '0) ? 2'd3 : 2'd2;
          end else begin
            w_q_nxt[0] = note_to_kc(w_new);
            w_qlen_nxt = 2'd1;
          end
        end else if (w_rep_fire) begin
          w_q_nxt[0]  = note_to_kc(r_sent);
          w_qlen_nxt  = 2'd1;
          w_state_nxt = T_LOAD;
        end
      end
      T_LOAD: begin
        w_start     = 1'b1;
        w_q_nxt[0]  = r_q[1];
        w_q_nxt[1]  = r_q[2];
        w_q_nxt[2]  = 8'h00;
        w_qlen_nxt  = r_qlen - 2'd1;
        w_state_nxt = T_SEND;
      end
      T_SEND: begin
        if (w_ready) begin
          w_state_nxt = (r_qlen != 2'd0) ? T_LOAD : T_IDLE;
        end
      end
      default: w_state_nxt = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= T_IDLE;
      r_sent  <= '0;
      r_q     <= '{default: '0};
      r_qlen  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sent  <= w_sent_nxt;
      r_q     <= w_q_nxt;
      r_qlen  <= w_qlen_nxt;
      r_busy  <= (w_state_nxt != T_IDLE);
    end
  end

  ps2_frame_tx #(
    .HALF_PERIOD (HALF_PERIOD),
    .GAP_CYCLES  (GAP_CYCLES)
  ) u_frame (
    .clk      (clk),
    .rst      (rst),
    .start    (w_start),
    .data     (r_q[0]),
    .ready    (w_ready),
    .done     (byte_done),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  assign busy = r_busy;

endmodule

// File: tb/tb_ps2_note_tx.sv
// Directed plus randomized bench for ps2_note_tx with a host-side frame decoder and a byte-sequence model.
module tb_ps2_note_tx;

  localparam int HP  = 4;
  localparam int GAP = 8;
  localparam int REP = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] note = 3'd0;
  logic       ps2_clk, ps2_data, busy, byte_done;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ps2_note_tx #(
    .HALF_PERIOD (HP),
    .GAP_CYCLES  (GAP),
    .REPEAT_CYC  (REP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .note      (note),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .busy      (busy),
    .byte_done (byte_done)
  );

  // Host model: sample data on every falling ps2_clk, decode 11-bit frames.
  int          bitn = 0;
  logic [10:0] raw_acc = '0;
  logic [10:0] last_raw = '0;
  logic [7:0]  rx_q[$];
  bit          ok_q[$];
  int          n_frames = 0;

  always @(negedge ps2_clk or posedge rst) begin
    if (rst) begin
      bitn = 0;
    end else begin
      raw_acc[bitn] = ps2_data;
      bitn++;
      if (bitn == 11) begin
        rx_q.push_back(raw_acc[8:1]);
        ok_q.push_back(raw_acc[0] == 1'b0 && raw_acc[10] == 1'b1 && (^raw_acc[9:1]) == 1'b1);
        last_raw = raw_acc;
        n_frames++;
        bitn = 0;
      end
    end
  end

  int n_done  = 0;
  int run     = 0;
  int min_gap = 1000;

  always @(negedge clk) begin
    if (!rst && byte_done === 1'b1) n_done++;
    if (ps2_clk === 1'b1 && ps2_data === 1'b1) begin
      run++;
    end else begin
      if (ps2_clk === 1'b1 && ps2_data === 1'b0 && run > 0 && run < min_gap) min_gap = run;
      run = 0;
    end
  end

  // Reference model: expected byte stream from successive note values.
  logic [7:0] exp_q[$];
  int         m_sent = 0;

  function automatic logic [7:0] code_of(input int n);
    case (n)
      1:       return 8'h16;
      2:       return 8'h1E;
      3:       return 8'h26;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_note(input int n);
    int nn;
    nn = (n >= 1 && n <= 3) ? n : 0;
    if (nn != m_sent) begin
      if (m_sent != 0) begin
        exp_q.push_back(8'hF0);
        exp_q.push_back(code_of(m_sent));
      end
      if (nn != 0) exp_q.push_back(code_of(nn));
      m_sent = nn;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    int low, cyc;
    low = 0;
    cyc = 0;
    while (low < 4 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b0) low++;
      else low = 0;
    end
    chk("settle", (low >= 4), 1);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_byte"}, rx_q.pop_front(), exp_q.pop_front());
      chk({tag, "_frame"}, ok_q.pop_front(), 1);
    end
    rx_q.delete();
    ok_q.delete();
    exp_q.delete();
    chk({tag, "_byte_done"}, n_done, n_frames);
  endtask

  initial begin
    int  k, bh, a, b;
    bit  idle_bad;

    // Reset and quiet idle.
    repeat (3) @(negedge clk);
    chk("rst_clk", ps2_clk, 1);
    chk("rst_data", ps2_data, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    idle_bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || busy !== 1'b0 || byte_done !== 1'b0) idle_bad = 1'b1;
    end
    chk("idle_100", idle_bad, 0);
    chk("idle_done", n_done, 0);

    // 0 -> 1: single 16h frame, latency and busy length.
    note = 3'd1;
    model_note(1);
    k = 0;
    bh = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (busy === 1'b1) bh++;
    end while (ps2_clk !== 1'b0 && k < 50);
    chk("latency", k, 2 + HP);
    while (busy === 1'b1 && bh < 500) begin
      @(negedge clk);
      if (busy === 1'b1) bh++;
    end
    chk("busy_len", bh, 1 + 22 * HP + GAP);
    settle();
    chk("raw16", last_raw, 11'h42C);
    check_stream("t2");

    // 1 -> 3: F0, 26 with an idle gap between frames.
    min_gap = 1000;
    note = 3'd3;
    model_note(3);
    settle();
    chk("gap_min", (min_gap >= GAP), 1);
    check_stream("t3");

    // 3 -> 2, 2 -> 0, then 5 (no key).
    note = 3'd2;
    model_note(2);
    settle();
    check_stream("t4a");
    note = 3'd0;
    model_note(0);
    settle();
    check_stream("t4b");
    note = 3'd5;
    model_note(5);
    repeat (50) @(negedge clk);
    settle();
    check_stream("t4c");

    // Change mid-frame is deferred to a second sequence.
    note = 3'd1;
    model_note(1);
    repeat (20) @(negedge clk);
    note = 3'd2;
    model_note(2);
    settle();
    check_stream("t5");

    // Randomized note changes, optionally a second change mid-sequence.
    for (int i = 0; i < 24; i++) begin
      a = int'($urandom_range(0, 7));
      note = 3'(a);
      model_note(a);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(2, 60)) @(negedge clk);
        b = int'($urandom_range(0, 7));
        note = 3'(b);
        model_note(b);
      end
      settle();
      check_stream("rand");
    end

    // Async reset in the middle of a low clock phase.
    note = 3'd0;
    model_note(0);
    settle();
    check_stream("t6pre");
    note = 3'd1;
    k = 0;
    while (ps2_clk !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t6_reach_lo", ps2_clk, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_clk", ps2_clk, 1);
    chk("t6_rst_data", ps2_data, 1);
    chk("t6_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    m_sent = 0;
    rx_q.delete();
    ok_q.delete();
    exp_q.delete();
    model_note(1);
    settle();
    check_stream("t6");

    repeat (REP + 150) @(negedge clk);
    settle();
`ifdef PS2_TYPEMATIC_EN
    chk("repeat_seen", (rx_q.size() > 0), 1);
    while (rx_q.size() > 0) chk("repeat_byte", rx_q.pop_front(), 8'h16);
    ok_q.delete();
`else
    check_stream("no_repeat");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
